// File: rtl/imem_responder.sv
// Memory-side responder for ICache miss fetches: word-addressed instruction store,
// fixed-latency single-pulse response, program-load write port and sticky error flags.
module imem_responder #(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned LATENCY      = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [31:0] ILLEGAL_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req_valid,
    input  logic [31:0] mem_req_addr,
    output logic        mem_resp_valid,
    output logic [31:0] data_out,
    output logic        busy,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data,
    input  logic        err_clear,
    output logic        err_overrun,
    output logic        err_range,
    output logic        err_misalign,
    output logic [15:0] req_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
    localparam int unsigned CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;
    localparam int unsigned CW       = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    logic [31:0]   mem [DEPTH];
    logic [1:0]    state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [31:0]   addr_q;

    logic          accept_c, overrun_c, capture_c;
    logic [31:0]   req_off_c, cap_addr_c, cap_off_c, prog_off_c;
    logic          req_in_range_c, cap_in_range_c, prog_in_range_c;
    logic          set_range_c, set_misalign_c;

    // Next-state and request decode
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept_c   = 1'b0;
        overrun_c  = 1'b0;
        case (state)
            S_IDLE, S_RESP: begin
                if (mem_req_valid) begin
                    accept_c = 1'b1;
                    if (LATENCY == 1) begin
                        state_next = S_RESP;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = CW'(CNT_INIT);
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                overrun_c = mem_req_valid;
                if (cnt == '0) begin
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase

        capture_c = (state_next == S_RESP);

        req_off_c      = mem_req_addr - BASE_ADDR;
        req_in_range_c = (req_off_c < SPAN);
        set_range_c    = accept_c && !req_in_range_c;
        set_misalign_c = accept_c && (mem_req_addr[1:0] != 2'b00);

        // With single-cycle latency the word is read on the accepting edge itself
        cap_addr_c     = (LATENCY == 1) ? mem_req_addr : addr_q;
        cap_off_c      = cap_addr_c - BASE_ADDR;
        cap_in_range_c = (cap_off_c < SPAN);

        prog_off_c      = prog_addr - BASE_ADDR;
        prog_in_range_c = (prog_off_c < SPAN);
    end

    // State, response and status registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            addr_q         <= '0;
            mem_resp_valid <= 1'b0;
            data_out       <= '0;
            busy           <= 1'b0;
            err_overrun    <= 1'b0;
            err_range      <= 1'b0;
            err_misalign   <= 1'b0;
            req_count      <= '0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            mem_resp_valid <= (state_next == S_RESP);
            busy           <= (state_next == S_WAIT);
            if (accept_c) begin
                addr_q <= mem_req_addr;
            end
            if (capture_c) begin
                data_out <= cap_in_range_c ? mem[cap_off_c[AW+1:2]] : ILLEGAL_WORD;
            end
            // New errors take priority over a simultaneous clear
            err_overrun  <= overrun_c      | (err_overrun  & ~err_clear);
            err_range    <= set_range_c    | (err_range    & ~err_clear);
            err_misalign <= set_misalign_c | (err_misalign & ~err_clear);
            if (accept_c && (req_count != 16'hFFFF)) begin
                req_count <= req_count + 16'd1;
            end
        end
    end

    // Program-load port; contents survive reset
    always_ff @(posedge clk) begin
        if (prog_we && prog_in_range_c) begin
            mem[prog_off_c[AW+1:2]] <= prog_data;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: LATENCY=1 and LATENCY=3 instances share stimulus.
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic        err_clear;

    logic        a_resp_valid, a_busy, a_err_overrun, a_err_range, a_err_misalign;
    logic [31:0] a_data_out;
    logic [15:0] a_req_count;
    logic        b_resp_valid, b_busy, b_err_overrun, b_err_range, b_err_misalign;
    logic [31:0] b_data_out;
    logic [15:0] b_req_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_responder #(.LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(a_resp_valid), .data_out(a_data_out), .busy(a_busy),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .err_clear(err_clear), .err_overrun(a_err_overrun), .err_range(a_err_range),
        .err_misalign(a_err_misalign), .req_count(a_req_count)
    );

    imem_responder #(.LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(b_resp_valid), .data_out(b_data_out), .busy(b_busy),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .err_clear(err_clear), .err_overrun(b_err_overrun), .err_range(b_err_range),
        .err_misalign(b_err_misalign), .req_count(b_req_count)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        step();
        prog_we   = 1'b0;
    endtask

    initial begin
        int waited;
        reset         = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        prog_we       = 1'b0;
        prog_addr     = '0;
        prog_data     = '0;
        err_clear     = 1'b0;
        step();
        step();

        check("rst_resp_valid", 32'(a_resp_valid), 32'd0);
        check("rst_data_out",   a_data_out,        32'd0);
        check("rst_busy",       32'(b_busy),       32'd0);
        check("rst_errs",       32'({a_err_overrun, a_err_range, a_err_misalign}), 32'd0);
        check("rst_count",      32'(a_req_count),  32'd0);
        reset = 1'b1;

        load(32'h10, 32'hDEAD_BEEF);
        load(32'h0,  32'h1111_1111);
        load(32'h4,  32'h2222_2222);
        load(32'h8,  32'h3333_3333);

        // Basic single-cycle fetch
        mem_req_valid = 1'b1; mem_req_addr = 32'h10;
        step();
        mem_req_valid = 1'b0;
        check("l1_resp_valid", 32'(a_resp_valid), 32'd1);
        check("l1_data",       a_data_out,        32'hDEAD_BEEF);
        check("l1_count",      32'(a_req_count),  32'd1);
        step();
        check("l1_resp_drop",  32'(a_resp_valid), 32'd0);
        check("l1_data_hold",  a_data_out,        32'hDEAD_BEEF);

        // Back-to-back requests
        do_reset();
        mem_req_valid = 1'b1; mem_req_addr = 32'h0;
        step();
        check("b2b_resp0", 32'(a_resp_valid), 32'd1);
        check("b2b_data0", a_data_out,        32'h1111_1111);
        mem_req_addr = 32'h4;
        step();
        mem_req_valid = 1'b0;
        check("b2b_resp1",  32'(a_resp_valid), 32'd1);
        check("b2b_data1",  a_data_out,        32'h2222_2222);
        check("b2b_count",  32'(a_req_count),  32'd2);
        step();
        check("b2b_idle",   32'(a_resp_valid), 32'd0);

        // Out-of-range fetch, clear, and set-beats-clear
        mem_req_valid = 1'b1; mem_req_addr = 32'h4000;
        step();
        mem_req_valid = 1'b0;
        check("range_data", a_data_out,        32'h0000_0013);
        check("range_flag", 32'(a_err_range),  32'd1);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("range_clr",  32'(a_err_range),  32'd0);
        mem_req_valid = 1'b1; mem_req_addr = 32'h4000; err_clear = 1'b1;
        step();
        mem_req_valid = 1'b0; err_clear = 1'b0;
        check("range_set_wins", 32'(a_err_range), 32'd1);
        step();

        // Misaligned fetch with same-edge write to the same word
        mem_req_valid = 1'b1; mem_req_addr = 32'h12;
        prog_we = 1'b1; prog_addr = 32'h10; prog_data = 32'hCAFE_F00D;
        step();
        mem_req_valid = 1'b0; prog_we = 1'b0;
        check("misalign_old",  a_data_out,          32'hDEAD_BEEF);
        check("misalign_flag", 32'(a_err_misalign), 32'd1);
        mem_req_valid = 1'b1; mem_req_addr = 32'h10;
        step();
        mem_req_valid = 1'b0;
        check("write_landed",  a_data_out,          32'hCAFE_F00D);

        // Out-of-range program write is dropped
        load(32'h4008, 32'h5555_5555);
        mem_req_valid = 1'b1; mem_req_addr = 32'h8;
        step();
        mem_req_valid = 1'b0;
        check("oor_write_drop", a_data_out, 32'h3333_3333);

        // LATENCY=3 timing and overrun
        do_reset();
        mem_req_valid = 1'b1; mem_req_addr = 32'h4;
        step();
        check("l3_c1_busy",  32'(b_busy),       32'd1);
        check("l3_c1_resp",  32'(b_resp_valid), 32'd0);
        mem_req_addr = 32'h8;
        step();
        mem_req_valid = 1'b0;
        check("l3_c2_busy",    32'(b_busy),        32'd1);
        check("l3_c2_resp",    32'(b_resp_valid),  32'd0);
        check("l3_overrun",    32'(b_err_overrun), 32'd1);
        check("l3_count",      32'(b_req_count),   32'd1);
        step();
        check("l3_c3_resp",  32'(b_resp_valid), 32'd1);
        check("l3_c3_busy",  32'(b_busy),       32'd0);
        check("l3_c3_data",  b_data_out,        32'h2222_2222);
        step();
        check("l3_c4_resp",  32'(b_resp_valid), 32'd0);

        // Reset while waiting drops the response
        do_reset();
        mem_req_valid = 1'b1; mem_req_addr = 32'h10;
        step();
        mem_req_valid = 1'b0;
        check("rmid_busy", 32'(b_busy), 32'd1);
        reset = 1'b0;
        step();
        check("rmid_busy0",  32'(b_busy),       32'd0);
        check("rmid_data0",  b_data_out,        32'd0);
        check("rmid_count0", 32'(b_req_count),  32'd0);
        check("rmid_errs0",  32'({b_err_overrun, b_err_range, b_err_misalign}), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rmid_no_resp", 32'(b_resp_valid), 32'd0);
        end

        // Store survives reset
        mem_req_valid = 1'b1; mem_req_addr = 32'h10;
        step();
        mem_req_valid = 1'b0;
        waited = 0;
        while (!b_resp_valid && waited < 10) begin
            step();
            waited++;
        end
        check("retain_timeout", 32'(b_resp_valid), 32'd1);
        check("retain_latency", 32'(waited),       32'd2);
        check("retain_data",    b_data_out,        32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
